reg_bank_demux: RTL and testbench
=================================

// Module: reg_bank_demux
// PURPOSE
//  Write side of the 16-entry register file: demultiplexes one 16-bit write
//  port onto 16 holding registers whose outputs feed mux_16to1 in0..in15.
//  - One-hot decodes wr_sel, updates exactly one register per write, returns
//    a one-cycle acknowledge.
//  - A clear sequencer walks all 16 registers back to RESET_VAL, one per cycle.
//
// PARAMETERS
//  WIDTH      16     data width of each register and of wr_data
//  RESET_VAL  16'h0  value loaded on reset and by the clear sequence
//
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  wr_en      in   1      write request, sampled at the rising edge
//  wr_sel     in   4      target register index 0..15
//  wr_data    in   WIDTH  write data
//  clr_req    in   1      start the clear sequence, sampled at the rising edge
//  busy       out  1      1 while the clear sequence runs
//  wr_ack     out  1      1-cycle pulse: the write was accepted
//  en_onehot  out  16     registered one-hot of the register updated last edge
//  r0..r15    out  WIDTH  register contents, to mux_16to1 in0..in15
//
// BEHAVIOUR
//  Reset (rst_n=0, async)
//  - r0..r15=RESET_VAL; busy=0, wr_ack=0, en_onehot=0, idx=0; state=IDLE.
//  - All outputs are registered.
//  States: IDLE, CLEAR.
//  IDLE, wr_en=1 and clr_req=0 at edge E:
//  - At E: r[wr_sel]<=wr_data; en_onehot<=16'b1<<wr_sel; wr_ack<=1.
//  - New value is visible on r<wr_sel> in the cycle after E (latency 1).
//  - No other register changes.
//  - wr_ack and en_onehot return to 0 at E+1 unless another write is accepted.
//  - Back-to-back writes are accepted every cycle.
//  - Same wr_sel on consecutive cycles: last write wins.
//  IDLE, clr_req=1 at edge E:
//  - At E: state<=CLEAR, idx<=0, busy<=1.
//  - A wr_en in the same cycle is dropped: no register change, wr_ack stays 0.
//    clr_req has priority.
//  CLEAR, at each edge:
//  - r[idx]<=RESET_VAL; en_onehot<=16'b1<<idx; idx<=idx+1.
//  - At the edge with idx=15: state<=IDLE, busy<=0, idx<=0.
//  - busy is high for exactly 16 cycles. Entry 0 is cleared at E+1 and entry
//    15 at E+16. busy falls at E+16.
//  - Registers not yet reached keep their old value.
//  - wr_en is ignored: no write, wr_ack=0.
//  - clr_req is ignored: no restart, no queueing.
//  - A write at edge E+17 (first IDLE edge) is accepted normally.
//  Width rules
//  - wr_sel is 4 bits, so every encoding maps to a register; there is no
//    invalid or default case.
//  - idx is a 4-bit counter and wraps 15->0 on exit.
//  Reset mid-operation
//  - rst_n low during CLEAR or during a write cycle aborts immediately.
//  - All registers and outputs go to their reset values asynchronously.
//  - No partial state survives.
//  - First legal write is at the first rising edge after rst_n is high.
//
// TESTING
//  1. Reset, then check r0..r15=0, busy=0, wr_ack=0, en_onehot=0.
//  2. wr_en=1, wr_sel=4'h5, wr_data=16'hBEEF for one cycle
//     -> next cycle r5=BEEF, en_onehot=16'h0020, wr_ack=1; all others 0.
//  3. Write 16 cycles back-to-back, sel=i, data=16'h1000+i
//     -> r_i=1000+i; wr_ack high for 16 consecutive cycles.
//     Then sel=3 twice, data 0x0001 then 0x0002 -> r3=0002.
//  4. Fill all registers with FFFF, pulse clr_req
//     -> busy high for exactly 16 cycles.
//     -> en_onehot walks 0001..8000; each r_i reads 0 starting the cycle
//        after its step.
//     A wr_en pulse mid-clear gives no wr_ack and no write.
//  5. clr_req and wr_en (sel=2, data=1234) in the same cycle
//     -> write dropped, r2=RESET_VAL after the clear, wr_ack never asserted.
//  6. Assert rst_n=0 asynchronously at idx=7 of a clear, between clock edges
//     -> all outputs reset immediately.
//     After release, write sel=9, data=0x00AA -> r9=00AA one cycle later.

Source files
------------

// File: rtl/reg_bank_demux.sv
// Write side of the 16-entry register file: one write port demultiplexed onto
// 16 holding registers, plus a sequencer that walks every entry back to RESET_VAL.
module reg_bank_demux #(
  parameter int unsigned       WIDTH     = 16,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [3:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_req,
  output logic             busy,
  output logic             wr_ack,
  output logic [15:0]      en_onehot,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] r4,
  output logic [WIDTH-1:0] r5,
  output logic [WIDTH-1:0] r6,
  output logic [WIDTH-1:0] r7,
  output logic [WIDTH-1:0] r8,
  output logic [WIDTH-1:0] r9,
  output logic [WIDTH-1:0] r10,
  output logic [WIDTH-1:0] r11,
  output logic [WIDTH-1:0] r12,
  output logic [WIDTH-1:0] r13,
  output logic [WIDTH-1:0] r14,
  output logic [WIDTH-1:0] r15
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e           state_q;
  logic [3:0]       idx_q;
  logic             busy_q;
  logic             wr_ack_q;
  logic [15:0]      en_onehot_q;
  logic [WIDTH-1:0] regs_q [16];

  logic [15:0]      sel_onehot_d;
  logic [15:0]      clr_onehot_d;

  always_comb begin
    sel_onehot_d = 16'b1 << wr_sel;
    clr_onehot_d = 16'b1 << idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      wr_ack_q    <= 1'b0;
      en_onehot_q <= '0;
      // NOTE: the storage array is reset because the bank contents are architecturally visible and must be RESET_VAL after reset.
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      case (state_q)
        IDLE: begin
          wr_ack_q    <= 1'b0;
          en_onehot_q <= '0;
          // A clear request wins over a simultaneous write, which is dropped.
          if (clr_req) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end else if (wr_en) begin
            regs_q[wr_sel] <= wr_data;
            en_onehot_q    <= sel_onehot_d;
            wr_ack_q       <= 1'b1;
          end
        end
        CLEAR: begin
          regs_q[idx_q] <= RESET_VAL;
          en_onehot_q   <= clr_onehot_d;
          wr_ack_q      <= 1'b0;
          idx_q         <= idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign wr_ack    = wr_ack_q;
  assign en_onehot = en_onehot_q;

  assign r0  = regs_q[0];
  assign r1  = regs_q[1];
  assign r2  = regs_q[2];
  assign r3  = regs_q[3];
  assign r4  = regs_q[4];
  assign r5  = regs_q[5];
  assign r6  = regs_q[6];
  assign r7  = regs_q[7];
  assign r8  = regs_q[8];
  assign r9  = regs_q[9];
  assign r10 = regs_q[10];
  assign r11 = regs_q[11];
  assign r12 = regs_q[12];
  assign r13 = regs_q[13];
  assign r14 = regs_q[14];
  assign r15 = regs_q[15];

endmodule

// File: tb/tb_reg_bank_demux.sv
// Directed bench for reg_bank_demux: writes, back-to-back writes, the clear
// sequence, clear/write priority, and asynchronous reset in the middle of a clear.
module tb_reg_bank_demux;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_sel;
  logic [15:0] wr_data;
  logic        clr_req;
  logic        busy;
  logic        wr_ack;
  logic [15:0] en_onehot;
  logic [15:0] r [16];

  int vectors;
  int miscompares;

  reg_bank_demux #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .clr_req   (clr_req),
    .busy      (busy),
    .wr_ack    (wr_ack),
    .en_onehot (en_onehot),
    .r0  (r[0]),  .r1  (r[1]),  .r2  (r[2]),  .r3  (r[3]),
    .r4  (r[4]),  .r5  (r[5]),  .r6  (r[6]),  .r7  (r[7]),
    .r8  (r[8]),  .r9  (r[9]),  .r10 (r[10]), .r11 (r[11]),
    .r12 (r[12]), .r13 (r[13]), .r14 (r[14]), .r15 (r[15])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance through one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_regs(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s r%0d", tag, i), {16'h0, r[i]}, {16'h0, exp});
    end
  endtask

  task automatic write(input logic [3:0] sel, input logic [15:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_sel  = 4'h0;
    wr_data = 16'h0;
    clr_req = 1'b0;

    // 1. Reset state
    #3;
    check_all_regs("reset", 16'h0000);
    check("reset busy", {31'h0, busy}, 32'd0);
    check("reset wr_ack", {31'h0, wr_ack}, 32'd0);
    check("reset en_onehot", {16'h0, en_onehot}, 32'h0);
    #9 rst_n = 1'b1;
    #1;

    // 2. Single write
    write(4'h5, 16'hBEEF);
    check("w5 r5", {16'h0, r[5]}, 32'h0000BEEF);
    check("w5 en_onehot", {16'h0, en_onehot}, 32'h00000020);
    check("w5 wr_ack", {31'h0, wr_ack}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (i != 5) check($sformatf("w5 other r%0d", i), {16'h0, r[i]}, 32'h0);
    end
    tick();
    check("w5 ack drop", {31'h0, wr_ack}, 32'd0);
    check("w5 onehot drop", {16'h0, en_onehot}, 32'h0);

    // 3. Back-to-back writes, then last-write-wins on r3
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_sel  = 4'(i);
      wr_data = 16'h1000 + 16'(i);
      tick();
      check($sformatf("b2b ack %0d", i), {31'h0, wr_ack}, 32'd1);
      check($sformatf("b2b onehot %0d", i), {16'h0, en_onehot}, 32'h1 << i);
      check($sformatf("b2b r%0d", i), {16'h0, r[i]}, 32'h1000 + i);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("b2b final r%0d", i), {16'h0, r[i]}, 32'h1000 + i);
    end
    wr_en   = 1'b1;
    wr_sel  = 4'h3;
    wr_data = 16'h0001;
    tick();
    check("r3 first", {16'h0, r[3]}, 32'h0001);
    wr_data = 16'h0002;
    tick();
    wr_en = 1'b0;
    check("r3 last wins", {16'h0, r[3]}, 32'h0002);
    check("r2 untouched", {16'h0, r[2]}, 32'h1002);

    // 4. Fill with FFFF, then clear; a mid-clear write and clr_req are ignored
    for (int i = 0; i < 16; i++) write(4'(i), 16'hFFFF);
    check_all_regs("fill", 16'hFFFF);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("clr start busy", {31'h0, busy}, 32'd1);
    check("clr start onehot", {16'h0, en_onehot}, 32'h0);
    check("clr start r0", {16'h0, r[0]}, 32'hFFFF);
    for (int k = 0; k < 16; k++) begin
      if (k == 7) begin
        wr_en   = 1'b1;
        wr_sel  = 4'hC;
        wr_data = 16'h5555;
      end
      if (k == 3) clr_req = 1'b1;
      tick();
      wr_en   = 1'b0;
      clr_req = 1'b0;
      check($sformatf("clr onehot %0d", k), {16'h0, en_onehot}, 32'h1 << k);
      check($sformatf("clr r%0d zero", k), {16'h0, r[k]}, 32'h0);
      check($sformatf("clr busy %0d", k), {31'h0, busy}, (k < 15) ? 32'd1 : 32'd0);
      check($sformatf("clr ack %0d", k), {31'h0, wr_ack}, 32'd0);
      if (k < 15) check($sformatf("clr r%0d kept", k + 1), {16'h0, r[k + 1]}, 32'hFFFF);
    end
    check_all_regs("after clr", 16'h0000);
    write(4'h0, 16'hA5A5);
    check("post clr ack", {31'h0, wr_ack}, 32'd1);
    check("post clr r0", {16'h0, r[0]}, 32'hA5A5);
    check("post clr busy", {31'h0, busy}, 32'd0);

    // 5. clr_req and wr_en together: clear wins, write dropped
    wr_en   = 1'b1;
    wr_sel  = 4'h2;
    wr_data = 16'h1234;
    clr_req = 1'b1;
    tick();
    wr_en   = 1'b0;
    clr_req = 1'b0;
    check("prio busy", {31'h0, busy}, 32'd1);
    check("prio ack", {31'h0, wr_ack}, 32'd0);
    check("prio r2", {16'h0, r[2]}, 32'h0);
    for (int k = 0; k < 16; k++) begin
      tick();
      check($sformatf("prio ack %0d", k), {31'h0, wr_ack}, 32'd0);
    end
    check("prio end busy", {31'h0, busy}, 32'd0);
    check("prio end r2", {16'h0, r[2]}, 32'h0);
    check("prio end r0", {16'h0, r[0]}, 32'h0);

    // 6. Asynchronous reset at idx=7 of a clear
    write(4'hF, 16'hCAFE);
    write(4'h8, 16'h7777);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check("mid clr onehot", {16'h0, en_onehot}, 32'h0040);
    check("mid clr r15", {16'h0, r[15]}, 32'hCAFE);
    #2 rst_n = 1'b0;
    #1;
    check("arst busy", {31'h0, busy}, 32'd0);
    check("arst ack", {31'h0, wr_ack}, 32'd0);
    check("arst onehot", {16'h0, en_onehot}, 32'h0);
    check_all_regs("arst", 16'h0000);
    #4 rst_n = 1'b1;
    write(4'h9, 16'h00AA);
    check("rel r9", {16'h0, r[9]}, 32'h00AA);
    check("rel ack", {31'h0, wr_ack}, 32'd1);
    check("rel busy", {31'h0, busy}, 32'd0);
    check("rel onehot", {16'h0, en_onehot}, 32'h0200);
    check("rel r8", {16'h0, r[8]}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
